// File: rtl/fib_blink_seq.sv
// Fibonacci term sequencer that blinks led_out term-value times per term.
// Built-in on/off/gap interval counters; start/stop control, busy/done status.
module fib_blink_seq #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_TERMS  = 5,
    parameter int ON_CYCLES  = 1600,
    parameter int OFF_CYCLES = 1599,
    parameter int GAP_CYCLES = 7997,
    parameter int CNT_WIDTH  = 13
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  start_in,
    input  logic                  stop_in,
    output logic                  led_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [DATA_WIDTH-1:0] term_out,
    output logic [2:0]            state_out
);

    localparam int REM_W = (NUM_TERMS < 2) ? 1 : $clog2(NUM_TERMS + 1);

    localparam logic [CNT_WIDTH-1:0] ON_LAST  = CNT_WIDTH'(ON_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] OFF_LAST = CNT_WIDTH'(OFF_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST = CNT_WIDTH'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ON   = 3'd2,
        S_OFF  = 3'd3,
        S_GAP  = 3'd4,
        S_NEXT = 3'd5,
        S_DONE = 3'd6
    } state_e;

    state_e                state;
    logic [DATA_WIDTH-1:0] f_prev;
    logic [DATA_WIDTH-1:0] f_cur;
    logic [DATA_WIDTH-1:0] f_sum;
    logic [DATA_WIDTH-1:0] blinks;
    logic [REM_W-1:0]      remaining;
    logic [CNT_WIDTH-1:0]  cnt;

    // Next Fibonacci term, wrapping modulo 2^DATA_WIDTH.
    assign f_sum = f_prev + f_cur;

    // Sequencer FSM: reset beats stop, stop beats start and every expiry.
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            state     <= S_IDLE;
            f_prev    <= '0;
            f_cur     <= '0;
            blinks    <= '0;
            remaining <= '0;
            cnt       <= '0;
        end else if (stop_in) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_in) begin
                        state <= S_LOAD;
                        cnt   <= '0;
                    end
                end
                S_LOAD: begin
                    f_prev    <= '0;
                    f_cur     <= DATA_WIDTH'(1);
                    remaining <= REM_W'(NUM_TERMS);
                    blinks    <= DATA_WIDTH'(1);
                    cnt       <= '0;
                    state     <= S_ON;
                end
                S_ON: begin
                    if (cnt == ON_LAST) begin
                        blinks <= blinks - DATA_WIDTH'(1);
                        cnt    <= '0;
                        state  <= S_OFF;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                S_OFF: begin
                    if (cnt == OFF_LAST) begin
                        cnt   <= '0;
                        state <= (blinks == '0) ? S_GAP : S_ON;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= S_NEXT;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                S_NEXT: begin
                    f_prev    <= f_cur;
                    f_cur     <= f_sum;
                    remaining <= remaining - REM_W'(1);
                    cnt       <= '0;
                    if (remaining == REM_W'(1)) begin
                        state <= S_DONE;
                    end else begin
                        blinks <= f_sum;
                        // A wrapped-to-zero term shows only its gap.
                        state  <= (f_sum != '0) ? S_ON : S_GAP;
                    end
                end
                S_DONE: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode the state register and f_cur only.
    always_comb begin
        led_out   = (state == S_ON);
        busy_out  = (state == S_LOAD) || (state == S_ON) ||
                    (state == S_OFF)  || (state == S_GAP) ||
                    (state == S_NEXT);
        done_out  = (state == S_DONE);
        term_out  = f_cur;
        state_out = state;
    end

endmodule
